// File: rtl/rv_mem_if.sv
// rv_mem_if: bus between the multicycle RISC-V core / program loader and
// the rv_mem memory subsystem.
//   Core side : imem_addr -> imem_datain, dmem_addr/dmem_dataout/memrw ->
//               dmem_datain, core_rst (core reset), halted.
//   Loader    : ld_valid/ld_addr/ld_data word strobe, ld_done pulse.
//   Output    : out_data / out_valid MMIO output port.
// master = core + loader side, slave = rv_mem.
interface rv_mem_if #(
    parameter int DPWIDTH = 32
);
    logic [DPWIDTH-1:0] imem_addr;
    logic [DPWIDTH-1:0] imem_datain;
    logic [DPWIDTH-1:0] dmem_addr;
    logic [DPWIDTH-1:0] dmem_dataout;
    logic               memrw;
    logic [DPWIDTH-1:0] dmem_datain;
    logic               ld_valid;
    logic [DPWIDTH-1:0] ld_addr;
    logic [DPWIDTH-1:0] ld_data;
    logic               ld_done;
    logic               core_rst;
    logic [DPWIDTH-1:0] out_data;
    logic               out_valid;
    logic               halted;

    modport master (
        output imem_addr, dmem_addr, dmem_dataout, memrw,
               ld_valid, ld_addr, ld_data, ld_done,
        input  imem_datain, dmem_datain, core_rst, out_data, out_valid, halted
    );

    modport slave (
        input  imem_addr, dmem_addr, dmem_dataout, memrw,
               ld_valid, ld_addr, ld_data, ld_done,
        output imem_datain, dmem_datain, core_rst, out_data, out_valid, halted
    );
endinterface

// File: rtl/rv_mem.sv
// rv_mem: memory subsystem for the multicycle RISC-V core.
// Word-addressed imem and dmem with combinational reads, an MMIO window
// (CYCLE counter, OUT port, HALT register) and a LOAD/RUN/HALTED state
// machine that keeps the core in reset while the program is loaded.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset (arrays are not cleared)
//   bus  - rv_mem_if slave: core fetch/load/store, loader strobes,
//          core_rst, halted, out_data/out_valid
module rv_mem #(
    parameter int               DPWIDTH    = 32,
    parameter int               IMEM_WORDS = 256,
    parameter int               DMEM_WORDS = 256,
    parameter logic [DPWIDTH-1:0] MMIO_BASE = 32'hFFFF_FF00
) (
    input  logic     clk,
    input  logic     rst,
    rv_mem_if.slave  bus
);
    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);
    localparam logic [DPWIDTH-1:0] IMEM_BYTES = DPWIDTH'(IMEM_WORDS * 4);
    localparam logic [DPWIDTH-1:0] DMEM_BYTES = DPWIDTH'(DMEM_WORDS * 4);

    // MMIO word offsets within the window
    localparam logic [5:0] OFF_CYCLE = 6'd0;
    localparam logic [5:0] OFF_OUT   = 6'd1;
    localparam logic [5:0] OFF_HALT  = 6'd2;

    typedef enum logic [1:0] {LOAD, RUN, HALTED} state_t;

    state_t             state;
    logic               core_rst;
    logic               halted;
    logic               out_valid;
    logic [DPWIDTH-1:0] out_data;
    logic [DPWIDTH-1:0] cycle_cnt;

    logic [DPWIDTH-1:0] imem [IMEM_WORDS];
    logic [DPWIDTH-1:0] dmem [DMEM_WORDS];

    logic               imem_in_range;
    logic               ld_in_range;
    logic               dmem_in_range;
    logic               mmio_hit;
    logic [5:0]         mmio_off;
    logic               run_store;
    logic [DPWIDTH-1:0] dmem_rd;

    assign imem_in_range = bus.imem_addr < IMEM_BYTES;
    assign ld_in_range   = bus.ld_addr < IMEM_BYTES;
    assign dmem_in_range = bus.dmem_addr < DMEM_BYTES;
    assign mmio_hit      = bus.dmem_addr[DPWIDTH-1:8] == MMIO_BASE[DPWIDTH-1:8];
    assign mmio_off      = bus.dmem_addr[7:2];
    assign run_store     = !rst && (state == RUN) && bus.memrw;

    // Combinational reads; MMIO decode wins over dmem decode.
    always_comb begin
        dmem_rd = '0;
        if (mmio_hit) begin
            case (mmio_off)
                OFF_CYCLE: dmem_rd = cycle_cnt;
                OFF_OUT:   dmem_rd = out_data;
                OFF_HALT:  dmem_rd = DPWIDTH'(halted);
                default:   dmem_rd = '0;
            endcase
        end else if (dmem_in_range) begin
            dmem_rd = dmem[bus.dmem_addr[DAW+1:2]];
        end
    end

    assign bus.imem_datain = imem_in_range ? imem[bus.imem_addr[IAW+1:2]] : '0;
    assign bus.dmem_datain = dmem_rd;
    assign bus.core_rst    = core_rst;
    assign bus.halted      = halted;
    assign bus.out_valid   = out_valid;
    assign bus.out_data    = out_data;

    // Array writes carry no reset so contents survive rst; writes are gated
    // by !rst so a reset edge never commits a pending store or load word.
    always_ff @(posedge clk) begin
        if (!rst && (state == LOAD) && bus.ld_valid && ld_in_range)
            imem[bus.ld_addr[IAW+1:2]] <= bus.ld_data;
        if (run_store && !mmio_hit && dmem_in_range)
            dmem[bus.dmem_addr[DAW+1:2]] <= bus.dmem_dataout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            core_rst  <= 1'b1;
            halted    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            cycle_cnt <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                LOAD: begin
                    if (bus.ld_done) begin
                        state    <= RUN;
                        core_rst <= 1'b0;
                    end
                end
                RUN: begin
                    cycle_cnt <= cycle_cnt + 1'b1;
                    if (bus.memrw && mmio_hit && (mmio_off == OFF_OUT)) begin
                        out_data  <= bus.dmem_dataout;
                        out_valid <= 1'b1;
                    end
                    if (bus.memrw && mmio_hit && (mmio_off == OFF_HALT)) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state    <= LOAD;
                    core_rst <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: doc/rv_mem.md
Name: rv_mem

Overview:
- Memory subsystem that sits directly downstream of the multicycle RISC-V core and consumes its memory interface: instruction address, data address, store data and memrw.
- Contains a word-addressed instruction memory, a word-addressed data memory, a small memory-mapped I/O (MMIO) window, and a program-loader state machine.
- The state machine fills instruction memory and holds the core in reset until loading completes, then halts the core on a software request.

Parameters:
- DPWIDTH, 32, data and address width.
- IMEM_WORDS, 256, instruction memory depth in words (power of two).
- DMEM_WORDS, 256, data memory depth in words (power of two).
- MMIO_BASE, 32'hFFFF_FF00, base address of the MMIO window.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- imem_addr  in  DPWIDTH  core instruction fetch address.
- imem_datain  out  DPWIDTH  instruction word to core.
- dmem_addr  in  DPWIDTH  core data address.
- dmem_dataout  in  DPWIDTH  core store data.
- memrw  in  1  1 = store, 0 = load.
- dmem_datain  out  DPWIDTH  load data to core.
- ld_valid  in  1  loader word strobe.
- ld_addr  in  DPWIDTH  loader byte address into imem.
- ld_data  in  DPWIDTH  loader word.
- ld_done  in  1  loader finished (1-cycle pulse).
- core_rst  out  1  reset to core.
- out_data  out  DPWIDTH  MMIO output port value.
- out_valid  out  1  1-cycle pulse on output port write.
- halted  out  1  core halted.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: FSM = LOAD, core_rst = 1, out_data = 0, out_valid = 0, halted = 0, cycle counter = 0.
- Reset does not clear the imem or dmem arrays.
- Addressing: word index = addr[log2(depth)+1:2]; addr[1:0] ignored.
- In-range test: addr < depth*4. Out-of-range reads return 0. Out-of-range writes are dropped.
- Reads are combinational, zero latency: imem_datain and dmem_datain follow their address in the same cycle, as the multicycle core expects.
- Data stores: memrw = 1 in a RUN cycle writes dmem at the clock edge. A read of the same address returns the new value from the next cycle.
- MMIO decode: addr[DPWIDTH-1:8] == MMIO_BASE[DPWIDTH-1:8]. The MMIO window takes priority over dmem decode.
  - Offset 0x00 CYCLE: read-only free-running counter. Counts only in RUN and wraps 2^DPWIDTH-1 -> 0. Writes ignored.
  - Offset 0x04 OUT: a write latches out_data and pulses out_valid for exactly 1 cycle. A read returns out_data. Back-to-back writes give consecutive pulses.
  - Offset 0x08 HALT: a write of any value moves the FSM to HALTED. A read returns {31'b0, halted}.
  - Other offsets: read 0, writes ignored.
- FSM states:
  - LOAD: core_rst = 1.
    - ld_valid writes ld_data into imem at ld_addr (out-of-range dropped).
    - ld_done -> RUN.
    - ld_valid and ld_done in the same cycle: the word is written, then the FSM enters RUN.
  - RUN: core_rst = 0 (first RUN cycle is the core's first out-of-reset cycle).
    - ld_valid ignored.
    - Stores and MMIO active.
    - HALT write -> HALTED.
  - HALTED: core_rst = 0, halted = 1.
    - All stores and MMIO writes suppressed.
    - CYCLE counter frozen.
    - out_valid = 0.
    - Reads still served.
    - Only rst leaves this state.
- rst mid-operation (any state) -> LOAD on the next edge. Array contents are kept, so a reload is optional: asserting ld_done alone reruns the existing program.
- memrw in LOAD: ignored.

Test Plan:
- Reset, then load words 0x00000013 @0x0 and 0x00100093 @0x4, ld_done -> core_rst drops the cycle after ld_done; imem_addr = 4 returns 0x00100093.
- RUN, memrw = 1, dmem_addr = 0x10, data = 0xDEADBEEF; next cycle memrw = 0, same address -> dmem_datain = 0xDEADBEEF. Out-of-range addr 0x400 write -> read returns 0 and dmem is unchanged.
- RUN, store 0xA5 to 0xFFFF_FF04, twice back-to-back -> out_valid high exactly 2 cycles, out_data = 0xA5.
- Read CYCLE at RUN cycles k and k+10 -> difference = 10. HALT write -> halted = 1 next cycle; CYCLE frozen; a later store to 0x20 does not change dmem.
- ld_valid with ld_done in the same cycle -> word written and RUN entered. ld_valid in RUN -> imem unchanged.
- rst asserted while in RUN, then ld_done only -> core_rst = 1 during LOAD, then 0; previously loaded imem and dmem contents intact.
